// File: rtl/stack_ctrl.sv
// Push/pop sequencer for a memory-resident stack whose SP lives in an external register file.
// Define STACK_BOUNDS_CHECK_EN to reject pushes at STACK_LIMIT and pops at STACK_TOP with sticky error flags.
module stack_ctrl #(
   parameter logic [7:0] STACK_TOP   = 8'd127,
   parameter logic [7:0] STACK_LIMIT = 8'd64,
   parameter logic [3:0] SP_ADDR     = 4'd15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_req,
   input  logic       pop_req,
   input  logic [7:0] push_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] pop_data,
   output logic       err_ovf,
   output logic       err_unf,
   input  logic [7:0] sp_in,
   output logic       rf_wr_en,
   output logic [3:0] rf_wr_addr,
   output logic [7:0] rf_wr_data,
   output logic [7:0] mem_addr,
   output logic       mem_wr,
   output logic       mem_rd,
   output logic [7:0] mem_wr_data,
   input  logic [7:0] mem_rd_data,
   input  logic       mem_ack
);

`ifdef STACK_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PUSH_MEM,
      POP_MEM,
      SP_WB,
      DONE
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_data;
   logic [7:0] r_sp;
   logic       r_is_push;
   logic [7:0] r_pop_data;
   logic       r_err_ovf;
   logic       r_err_unf;

   logic       w_accept;
   logic       w_reject_ovf;
   logic       w_reject_unf;

   // push has priority over pop when both are requested
   assign w_accept     = (r_state == IDLE) && (push_req || pop_req);
   assign w_reject_ovf = BOUNDS_EN && push_req && (sp_in == STACK_LIMIT);
   assign w_reject_unf = BOUNDS_EN && !push_req && pop_req && (sp_in == STACK_TOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_data     <= 8'd0;
         r_sp       <= 8'd0;
         r_is_push  <= 1'b0;
         r_pop_data <= 8'd0;
         r_err_ovf  <= 1'b0;
         r_err_unf  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_data    <= push_data;
            r_sp      <= sp_in;
            r_is_push <= push_req;
            // rejected requests only raise their own flag; a performed one clears both
            if (w_reject_ovf) begin
               r_err_ovf <= 1'b1;
            end else if (w_reject_unf) begin
               r_err_unf <= 1'b1;
            end else begin
               r_err_ovf <= 1'b0;
               r_err_unf <= 1'b0;
            end
         end
         if ((r_state == POP_MEM) && mem_ack) begin
            r_pop_data <= mem_rd_data;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      busy        = (r_state != IDLE);
      done        = 1'b0;
      mem_wr      = 1'b0;
      mem_rd      = 1'b0;
      mem_addr    = 8'd0;
      mem_wr_data = 8'd0;
      rf_wr_en    = 1'b0;
      rf_wr_data  = 8'd0;
      case (r_state)
         IDLE: begin
            if (push_req) begin
               w_next = w_reject_ovf ? DONE : PUSH_MEM;
            end else if (pop_req) begin
               w_next = w_reject_unf ? DONE : POP_MEM;
            end
         end
         PUSH_MEM: begin
            mem_wr      = 1'b1;
            mem_addr    = r_sp - 8'd1;
            mem_wr_data = r_data;
            if (mem_ack) begin
               w_next = SP_WB;
            end
         end
         POP_MEM: begin
            mem_rd   = 1'b1;
            mem_addr = r_sp;
            if (mem_ack) begin
               w_next = SP_WB;
            end
         end
         SP_WB: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = r_is_push ? (r_sp - 8'd1) : (r_sp + 8'd1);
            w_next     = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign rf_wr_addr = SP_ADDR;
   assign pop_data   = r_pop_data;
   assign err_ovf    = r_err_ovf;
   assign err_unf    = r_err_unf;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter STACK_TOP, default 8'd127, is the empty-stack SP value and matches the register file's SP reset value.
REQ-002 Parameter STACK_LIMIT, default 8'd64, is the lowest SP value; a push at this SP is full.
REQ-003 Parameter SP_ADDR, default 4'd15, is the register-file index of SP.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port push_req, input, 1: push request, sampled only in IDLE.
REQ-007 Port pop_req, input, 1: pop request, sampled only in IDLE.
REQ-008 Port push_data, input, 8: data to push, sampled when a push is accepted.
REQ-009 Port busy, output, 1: high whenever the state is not IDLE.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port pop_data, output, 8: last popped byte, held until the next pop completes.
REQ-012 Port err_ovf / err_unf, output, 1 each: overflow and underflow flags.
REQ-013 Port sp_in, input, 8: current SP from the register file.
REQ-014 Port rf_wr_en, output, 1: register-file write strobe for SP.
REQ-015 Port rf_wr_addr, output, 4: constant SP_ADDR.
REQ-016 Port rf_wr_data, output, 8: new SP value.
REQ-017 Ports mem_addr, output, 8; mem_wr, output, 1; mem_rd, output, 1; mem_wr_data, output, 8: data-memory request.
REQ-018 Ports mem_rd_data, input, 8; mem_ack, input, 1: data-memory response.

Function
REQ-019 States SHALL be IDLE, PUSH_MEM, POP_MEM, SP_WB and DONE.
REQ-020 In IDLE with push_req=1, SHALL latch push_data and sp_in and go to PUSH_MEM; push wins if push_req and pop_req are both high.
REQ-021 In IDLE with pop_req=1 and push_req=0, SHALL latch sp_in and go to POP_MEM.
REQ-022 Requests while busy=1 SHALL be ignored and not queued.
REQ-023 PUSH_MEM SHALL drive mem_wr=1, mem_addr=SP-1 and mem_wr_data=latched data, held stable until the cycle mem_ack=1, then go to SP_WB.
REQ-024 POP_MEM SHALL drive mem_rd=1 and mem_addr=SP until the cycle mem_ack=1, capture mem_rd_data into pop_data in that cycle, then go to SP_WB.
REQ-025 SP_WB SHALL assert rf_wr_en for exactly one cycle, with rf_wr_data=SP-1 for a push or SP+1 for a pop (8-bit arithmetic), then go to DONE.
REQ-026 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-027 With mem_ack high in the first memory cycle, done SHALL occur 3 cycles after the accepting edge; each wait cycle adds one cycle.
REQ-028 mem_wr, mem_rd and rf_wr_en SHALL never be asserted together.
REQ-029 mem_ack SHALL be ignored outside PUSH_MEM and POP_MEM.

Reset
REQ-030 Asserting rst SHALL immediately force IDLE and drive busy, done, rf_wr_en, mem_wr, mem_rd, err_ovf, err_unf, pop_data, mem_addr, mem_wr_data and rf_wr_data to 0; rf_wr_addr stays SP_ADDR.
REQ-031 A reset during PUSH_MEM, POP_MEM or SP_WB SHALL abandon the operation with no further memory or SP write.
REQ-032 After rst deasserts, the first rising edge SHALL sample requests normally.

Configuration
REQ-033 With macro STACK_BOUNDS_CHECK_EN defined, a push at sp_in==STACK_LIMIT or a pop at sp_in==STACK_TOP SHALL go straight to DONE with no memory access and no SP write.
REQ-034 In that rejected case, the controller SHALL set err_ovf or err_unf respectively in the DONE cycle.
REQ-035 Both error flags SHALL stay set until the next accepted request, which clears them.
REQ-036 With STACK_BOUNDS_CHECK_EN undefined, there SHALL be no bounds checks: SP wraps modulo 256, and err_ovf and err_unf are constant 0.

Verification
REQ-037 Push-pop round trip: reset, sp_in=127, push 8'hA5 with mem_ack held at 1 -> mem write to addr 126 of data A5, rf_wr_data=126, done 3 cycles after acceptance; then sp_in=126, pop with memory returning A5 -> read at addr 126, pop_data=A5, rf_wr_data=127.
REQ-038 Wait states: push with mem_ack delayed 4 cycles -> mem_addr and mem_wr_data stay stable throughout, and done occurs 7 cycles after acceptance.
REQ-039 Request handling: push_req and pop_req asserted together -> a push is performed; a pop_req pulse while busy -> no second operation.
REQ-040 Bounds check (macro defined): sp_in=64 push -> err_ovf=1, no mem_wr and no rf_wr_en; sp_in=127 pop -> err_unf=1; a following valid push clears both flags.
REQ-041 Reset mid-operation: rst asserted during PUSH_MEM wait -> outputs are 0 within the same cycle, no rf_wr_en ever follows, and a new push after reset completes normally.
REQ-042 No bounds check (macro undefined): sp_in=0 push -> mem write to addr 255, rf_wr_data=255, err_ovf=0.
